// File: rtl/leaf_ni_tx.sv
// leaf_ni_tx: clocked transmit network interface for a leaf input port of the
// asynchronous tree router. It buffers 9-bit flits from a valid/ready producer
// in a small FIFO and sends each one as a 1-of-2 x 9 dual-rail codeword. The
// codeword goes out under a four-phase return-to-zero handshake on out_e.
//
// Optional feature macro: LEAF_NI_TX_COUNT_EN
//   When defined, the tx_count port exists. It is a 16-bit wrapping count of
//   completed flits. When undefined, the port and the counter are absent.
//
// FSM states
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   S_IDLE     | rails neutral; load the head flit once e_s=1 and FIFO non-empty
//   S_WAIT_ACK | codeword on rails; wait for a fresh e_s=0 (acknowledge)
//   S_NEUTRAL  | rails neutral; wait for a fresh e_s=1 (receiver released)

module leaf_ni_tx #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        _RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_data,
    output logic [8:0]  out_d1,
    output logic [8:0]  out_d0,
    input  logic        out_e
`ifdef LEAF_NI_TX_COUNT_EN
    ,
    output logic [15:0] tx_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_NEUTRAL  = 2'd2
    } state_t;

    logic [8:0]             r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [8:0]             r_d1;
    logic [8:0]             r_d0;
    state_t                 r_state;

    state_t                 w_state_nxt;
    logic                   w_e_s;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_clear;
    logic                   w_not_empty;

    assign in_ready    = (r_count != L_FULL);
    assign w_not_empty = (r_count != '0);
    // A push during reset is dropped; the reset branch below also wins.
    assign w_push      = in_valid && in_ready && _RESET;
    assign w_pop       = w_load;
    assign w_e_s       = r_sync[SYNC_STAGES-1];

    // The rails are registered so all 18 wires switch on the same edge.
    assign out_d1 = r_d1;
    assign out_d0 = r_d0;

    // Synchronize the asynchronous enable. Reset to 1 matches a receiver
    // that is idle and ready.
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], out_e};
        end
    end

    // FIFO storage. There is no reset: the count is cleared, so stale entries are never read.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy. A push and a pop together leave the count unchanged.
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Handshake state register.
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and rail-update decode. Each state waits on the opposite
    // level from the one that got it there, so every observed level is fresh.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_e_s && w_not_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!w_e_s) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_NEUTRAL;
                end
            end
            S_NEUTRAL: begin
                if (w_e_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Rail registers. A load writes the flit and its complement, so no bit
    // pair is ever 11. Reset withdraws any codeword at once.
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            r_d1 <= '0;
            r_d0 <= '0;
        end else if (w_load) begin
            r_d1 <= r_mem[r_rd_ptr];
            r_d0 <= ~r_mem[r_rd_ptr];
        end else if (w_clear) begin
            r_d1 <= '0;
            r_d0 <= '0;
        end
    end

`ifdef LEAF_NI_TX_COUNT_EN
    logic [15:0] r_tx_count;

    // Count completed flits (WAIT_ACK to NEUTRAL); the counter wraps at 16 bits.
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            r_tx_count <= '0;
        end else if (w_clear) begin
            r_tx_count <= r_tx_count + 16'd1;
        end
    end

    assign tx_count = r_tx_count;
`endif

endmodule

// File: tb/tb_leaf_ni_tx.sv
// Directed testbench for leaf_ni_tx. The bench drives its inputs 1 ns after
// each rising edge and samples the outputs at the same time.
module tb_leaf_ni_tx;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_data;
    logic [8:0]  out_d1;
    logic [8:0]  out_d0;
    logic        out_e;
    logic        e_drv;
    bit          echo;
`ifdef LEAF_NI_TX_COUNT_EN
    logic [15:0] tx_count;
`endif

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [8:0]  tx_q[$];

    // An instant-echo receiver drops the enable while a codeword is present.
    assign out_e = echo ? ((out_d1 | out_d0) == 9'd0) : e_drv;

    always #5 CLK = ~CLK;

    leaf_ni_tx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK      (CLK),
        ._RESET   (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_d1   (out_d1),
        .out_d0   (out_d0),
        .out_e    (out_e)
`ifdef LEAF_NI_TX_COUNT_EN
        ,
        .tx_count (tx_count)
`endif
    );

    // Offer the head of the queue to the producer inputs.
    task automatic present();
        if (tx_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = tx_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 9'd0;
        end
    endtask

    // Advance one clock and retire the offered flit if the DUT took it.
    task automatic step();
        bit         acc;
        logic [8:0] dummy;
        acc = in_valid && in_ready && rst_n;
        @(posedge CLK);
        #1;
        cyc++;
        if (acc) begin
            dummy = tx_q.pop_front();
            present();
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tx_q.delete();
        present();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Four-phase receiver. It waits pre cycles before acknowledging and hold
    // cycles before releasing.
    task automatic rx(input int pre, input int hold,
                      output logic [8:0] d1, output logic [8:0] d0, output bit to);
        int n;
        to    = 1'b0;
        e_drv = 1'b1;
        n = 0;
        while ((out_d1 | out_d0) == 9'd0 && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) to = 1'b1;
        d1 = out_d1;
        d0 = out_d0;
        repeat (pre) step();
        e_drv = 1'b0;
        n = 0;
        while ((out_d1 | out_d0) != 9'd0 && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) to = 1'b1;
        repeat (hold) step();
        e_drv = 1'b1;
    endtask

    task automatic test_reset();
        e_drv    = 1'b1;
        echo     = 1'b0;
        rst_n    = 1'b0;
        tx_q.delete();
        in_valid = 1'b1;
        in_data  = 9'h0FF;
        repeat (3) step();
        tests++;
        if (out_d1 !== 9'd0 || out_d0 !== 9'd0) begin
            fails++;
            $display("FAIL reset_rails: d1=%h d0=%h expected 000/000", out_d1, out_d0);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
`ifdef LEAF_NI_TX_COUNT_EN
        tests++;
        if (tx_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", tx_count);
        end
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) step();
        tests++;
        if (out_d1 !== 9'd0 || out_d0 !== 9'd0) begin
            fails++;
            $display("FAIL reset_nostore: d1=%h d0=%h expected 000/000", out_d1, out_d0);
        end
    endtask

    task automatic test_single();
        e_drv = 1'b1;
        echo  = 1'b0;
        do_reset(2);
        repeat (3) step();
        tx_q.push_back(9'h1A5);
        present();
        step();
        tests++;
        if (out_d1 !== 9'd0 || out_d0 !== 9'd0) begin
            fails++;
            $display("FAIL single_latency: d1=%h d0=%h expected 000/000 at push edge", out_d1, out_d0);
        end
        step();
        tests++;
        if (out_d1 !== 9'h1A5 || out_d0 !== 9'h05A) begin
            fails++;
            $display("FAIL single_codeword: d1=%h d0=%h expected 1a5/05a", out_d1, out_d0);
        end
        e_drv = 1'b0;
        step();
        step();
        tests++;
        if (out_d1 !== 9'h1A5 || out_d0 !== 9'h05A) begin
            fails++;
            $display("FAIL single_hold: d1=%h d0=%h expected 1a5/05a before ack edge", out_d1, out_d0);
        end
        step();
        tests++;
        if (out_d1 !== 9'd0 || out_d0 !== 9'd0) begin
            fails++;
            $display("FAIL single_neutral: d1=%h d0=%h expected 000/000", out_d1, out_d0);
        end
        e_drv = 1'b1;
        repeat (4) step();
        tests++;
        if (out_d1 !== 9'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_idle: d1=%h ready=%b expected 000/1", out_d1, in_ready);
        end
`ifdef LEAF_NI_TX_COUNT_EN
        tests++;
        if (tx_count !== 16'd1) begin
            fails++;
            $display("FAIL single_count: got %0d expected 1", tx_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [8:0] exp [5];
        logic [8:0] d1, d0;
        bit         to;
        exp[0] = 9'h101; exp[1] = 9'h0B2; exp[2] = 9'h1C3; exp[3] = 9'h0D4; exp[4] = 9'h1E5;
        e_drv = 1'b0;
        echo  = 1'b0;
        do_reset(2);
        repeat (3) step();
        for (int i = 0; i < 5; i++) tx_q.push_back(exp[i]);
        present();
        repeat (4) step();
        tests++;
        if (in_ready !== 1'b0 || tx_q.size() != 1) begin
            fails++;
            $display("FAIL bp_full: ready=%b pending=%0d expected 0/1", in_ready, tx_q.size());
        end
        repeat (5) step();
        tests++;
        if (in_ready !== 1'b0 || tx_q.size() != 1 || out_d1 !== 9'd0) begin
            fails++;
            $display("FAIL bp_held: ready=%b pending=%0d d1=%h expected 0/1/000", in_ready, tx_q.size(), out_d1);
        end
        for (int i = 0; i < 5; i++) begin
            rx(0, 0, d1, d0, to);
            tests++;
            if (to || d1 !== exp[i] || d0 !== ~exp[i]) begin
                fails++;
                $display("FAIL bp_order[%0d]: d1=%h d0=%h timeout=%b expected %h/%h", i, d1, d0, to, exp[i], ~exp[i]);
            end
        end
        tests++;
        if (tx_q.size() != 0) begin
            fails++;
            $display("FAIL bp_fifth: pending=%0d expected 0", tx_q.size());
        end
    endtask

    task automatic test_throughput();
        int         t_load [10];
        logic [8:0] d_load [10];
        logic [8:0] exp    [10];
        int         nl;
        bit         prev_nz;
        bit         pair_bad;
        bit         bad_cw;
        e_drv = 1'b1;
        echo  = 1'b1;
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            exp[i] = 9'((i * 37 + 5) & 9'h1FF);
            tx_q.push_back(exp[i]);
        end
        present();
        nl = 0;
        prev_nz  = 1'b0;
        pair_bad = 1'b0;
        bad_cw   = 1'b0;
        repeat (110) begin
            step();
            if ((out_d1 & out_d0) != 9'd0) pair_bad = 1'b1;
            if ((out_d1 | out_d0) != 9'd0 && !prev_nz) begin
                if (out_d0 !== ~out_d1) bad_cw = 1'b1;
                if (nl < 10) begin
                    t_load[nl] = cyc;
                    d_load[nl] = out_d1;
                end
                nl++;
            end
            prev_nz = ((out_d1 | out_d0) != 9'd0);
        end
        echo = 1'b0;
        tests++;
        if (nl != 10) begin
            fails++;
            $display("FAIL tp_count: codewords=%0d expected 10", nl);
        end
        tests++;
        if (pair_bad || bad_cw) begin
            fails++;
            $display("FAIL tp_rails: pair11=%b bad_codeword=%b expected 0/0", pair_bad, bad_cw);
        end
        for (int i = 0; i < 10 && i < nl; i++) begin
            tests++;
            if (d_load[i] !== exp[i]) begin
                fails++;
                $display("FAIL tp_data[%0d]: got %h expected %h", i, d_load[i], exp[i]);
            end
            if (i > 0) begin
                tests++;
                if (t_load[i] - t_load[i-1] != 7) begin
                    fails++;
                    $display("FAIL tp_period[%0d]: got %0d cycles expected 7", i, t_load[i] - t_load[i-1]);
                end
            end
        end
`ifdef LEAF_NI_TX_COUNT_EN
        tests++;
        if (tx_count !== 16'd10) begin
            fails++;
            $display("FAIL tp_txcount: got %0d expected 10", tx_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [8:0] d1, d0;
        bit         to;
        bit         leak;
        int         n;
        e_drv = 1'b0;
        echo  = 1'b0;
        do_reset(2);
        repeat (3) step();
        tx_q.push_back(9'h111);
        tx_q.push_back(9'h022);
        tx_q.push_back(9'h133);
        present();
        repeat (3) step();
        e_drv = 1'b1;
        n = 0;
        while (out_d1 == 9'd0 && n < 10) begin
            step();
            n++;
        end
        tests++;
        if (out_d1 !== 9'h111 || out_d0 !== 9'h0EE) begin
            fails++;
            $display("FAIL mid_load: d1=%h d0=%h expected 111/0ee", out_d1, out_d0);
        end
        rst_n = 1'b0;
        step();
        tests++;
        if (out_d1 !== 9'd0 || out_d0 !== 9'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_withdraw: d1=%h d0=%h ready=%b expected 000/000/1", out_d1, out_d0, in_ready);
        end
        step();
        rst_n = 1'b1;
        leak = 1'b0;
        repeat (10) begin
            step();
            if ((out_d1 | out_d0) != 9'd0) leak = 1'b1;
        end
        tests++;
        if (leak) begin
            fails++;
            $display("FAIL mid_flushed: stale codeword seen after reset, expected none");
        end
        tx_q.push_back(9'h0C3);
        present();
        rx(1, 1, d1, d0, to);
        tests++;
        if (to || d1 !== 9'h0C3 || d0 !== 9'h13C) begin
            fails++;
            $display("FAIL mid_newflit: d1=%h d0=%h timeout=%b expected 0c3/13c", d1, d0, to);
        end
`ifdef LEAF_NI_TX_COUNT_EN
        tests++;
        if (tx_count !== 16'd1) begin
            fails++;
            $display("FAIL mid_txcount: got %0d expected 1", tx_count);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [8:0] d1, d0;
        logic [8:0] e;
        bit         to;
        e_drv = 1'b1;
        echo  = 1'b0;
        do_reset(2);
        for (int i = 0; i < 9; i++) tx_q.push_back(9'(i));
        present();
        for (int i = 0; i < 9; i++) begin
            rx(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d1, d0, to);
            e = 9'(i);
            tests++;
            if (to || d1 !== e || d0 !== ~e) begin
                fails++;
                $display("FAIL wrap[%0d]: d1=%h d0=%h timeout=%b expected %h/%h", i, d1, d0, to, e, ~e);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 9'd0;
        e_drv    = 1'b1;
        echo     = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
